adc_multi_chnl_pkt: RTL and testbench
=====================================

Name: adc_multi_chnl_pkt

Overview:
- Parametrised successor to the fixed 8-channel AD7606 packetiser.
- Captures simultaneous N-channel sample sets from an ADC driver and applies a runtime channel mask.
- Buffers P_SETS_PER_PKT sets per packet in a ping-pong bank pair, then serialises each packet as a byte stream (header, mask, sequence, payload) with len/last/valid and ready backpressure.
- Sits between the ADC driver and the command/UART upload path.

Parameters:
- P_CHNL_NUM, 8, channel count; legal 1..8.
- P_DATA_WIDTH, 16, bits per sample; legal 8, 16, 24 or 32. BYTES = P_DATA_WIDTH/8.
- P_SETS_PER_PKT, 4, sample sets per packet; must satisfy 3 + P_SETS_PER_PKT*P_CHNL_NUM*BYTES <= 255.
- P_HEADER, 8'hA5, first byte of every packet.

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, asynchronous active-low reset.
- i_enable, input, 1, capture enable (level).
- i_chnl_mask, input, P_CHNL_NUM, bit k set = channel k included.
- i_sample_data, input, P_CHNL_NUM*P_DATA_WIDTH, channel k occupies bits [k*W +: W].
- i_sample_valid, input, 1, one-cycle strobe; all channels valid together.
- i_adc_ready, input, 1, downstream accepts a byte.
- o_adc_data, output, 8, stream byte.
- o_adc_len, output, 8, total packet length in bytes; constant for the whole packet.
- o_adc_last, output, 1, final byte of the packet.
- o_adc_valid, output, 1, byte valid.
- o_overflow, output, 1, sticky; a sample set was dropped.
- o_pkt_cnt, output, 16, packets completed; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (i_rst=0, async): all outputs 0; both banks empty; sequence counter 0; emitter in IDLE.
- Capture:
  - A set is written when i_sample_valid=1, i_enable=1, the latched mask is nonzero and the fill bank is not full.
  - The mask is latched on the first set written into an empty bank; mask changes mid-bank are ignored until the next bank.
  - If i_chnl_mask=0 at a bank's first set, the set is ignored.
- Bank swap: when the fill bank reaches P_SETS_PER_PKT sets it is marked full and handed to the emitter.
  - Filling continues in the other bank only if that bank is empty.
  - A set arriving while both banks are full or emitting is dropped and o_overflow is set. o_overflow clears only on reset.
- i_enable low: a partially filled bank is discarded at once (count to 0). Full banks and a packet in flight complete normally.
- Emitter FSM: IDLE -> HEAD -> MASK -> SEQ -> DATA -> IDLE.
  - IDLE: moves to HEAD the cycle after a full bank exists, so o_adc_valid rises 1 cycle after the swap. If both banks are full, the older bank goes first.
  - HEAD emits P_HEADER. MASK emits the latched mask, zero-extended to 8 bits. SEQ emits the sequence counter.
  - DATA emits, for set 0..S-1, enabled channels in ascending index order, each sample MSB byte first.
- Length: len = 3 + P_SETS_PER_PKT*popcount(mask)*BYTES, computed when the bank is latched.
- Handshake:
  - o_adc_data, o_adc_len and o_adc_last are held stable while o_adc_valid=1 and i_adc_ready=0. A byte advances only on valid&ready.
  - o_adc_valid stays high continuously within a packet.
  - o_adc_last=1 only on the final byte.
- Packet end: on the final-byte handshake the bank is freed, the sequence counter increments (8-bit wrap), o_pkt_cnt increments, and the FSM returns to IDLE. There is at least one idle cycle (o_adc_valid=0) between packets.
- Simultaneous events: a capture into one bank and emission from the other in the same cycle are independent. Freeing a bank and a set arriving in the same cycle means the set is accepted into the freed bank.
- Reset mid-packet: the stream aborts immediately (o_adc_valid=0); all state is cleared.

Test Plan:
- Defaults, mask 8'h01, 4 sets with ch0 = 0x1234, 0x5678, 0x9ABC, 0xDEF0, ready=1 -> bytes A5 01 00 12 34 56 78 9A BC DE F0; len=11 on every byte; last on F0; o_pkt_cnt=1.
- Mask 8'h81, ch0=0x0102, ch7=0x0304, 4 identical sets -> len=19; payload repeats 01 02 03 04; second packet carries SEQ=01.
- Backpressure: toggle i_adc_ready every other cycle during the packet above -> no byte lost or duplicated; data stable whenever ready=0.
- Overflow: sets every cycle with ready=0 -> two banks fill; the 9th set is dropped and o_overflow=1; releasing ready emits 2 complete packets.
- Deassert i_enable after 2 of 4 sets, then re-enable and send 4 sets -> exactly one packet, containing only the later 4 sets.
- Pull i_rst low during the DATA state -> o_adc_valid=0 asynchronously; after release, the next packet starts with SEQ=00 and o_pkt_cnt=0.

Source files
------------

// File: rtl/adc_multi_chnl_pkt.sv
// rtl/adc_multi_chnl_pkt.sv - N-channel ADC sample packetiser with ping-pong banks and byte-stream emitter
module adc_multi_chnl_pkt #(
    parameter int         P_CHNL_NUM     = 8,
    parameter int         P_DATA_WIDTH   = 16,
    parameter int         P_SETS_PER_PKT = 4,
    parameter logic [7:0] P_HEADER       = 8'hA5
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_enable,
    input  logic [P_CHNL_NUM-1:0]              i_chnl_mask,
    input  logic [P_CHNL_NUM*P_DATA_WIDTH-1:0] i_sample_data,
    input  logic                               i_sample_valid,
    input  logic                               i_adc_ready,
    output logic [7:0]                         o_adc_data,
    output logic [7:0]                         o_adc_len,
    output logic                               o_adc_last,
    output logic                               o_adc_valid,
    output logic                               o_overflow,
    output logic [15:0]                        o_pkt_cnt
);

    localparam int LP_BYTES = P_DATA_WIDTH / 8;
    localparam int LP_CW    = (P_CHNL_NUM > 1) ? $clog2(P_CHNL_NUM) : 1;
    localparam int LP_SW    = (P_SETS_PER_PKT > 1) ? $clog2(P_SETS_PER_PKT) : 1;
    localparam int LP_SETW  = P_CHNL_NUM * P_DATA_WIDTH;
    localparam logic [1:0]       LP_BYTE_LAST = 2'(LP_BYTES - 1);
    localparam logic [LP_SW-1:0] LP_SET_LAST  = LP_SW'(P_SETS_PER_PKT - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_HEAD, ST_MASK, ST_SEQ, ST_DATA} state_t;

    logic [LP_SETW-1:0]    r_mem [2][P_SETS_PER_PKT];
    logic [1:0]            r_full;
    logic [LP_SW-1:0]      r_cnt [2];
    logic [P_CHNL_NUM-1:0] r_mask [2];
    logic [7:0]            r_len [2];
    logic                  r_fill;
    logic                  r_old;
    logic                  r_ovf;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_emit;
    logic [LP_SW-1:0]      r_set;
    logic [LP_CW-1:0]      r_ch;
    logic [1:0]            r_byte;
    logic [7:0]            r_bcnt;
    logic [7:0]            r_seq;
    logic [15:0]           r_pkt_cnt;

    logic                  w_hs;
    logic                  w_free;
    logic [1:0]            w_full_eff;
    logic                  w_fill;
    logic                  w_room;
    logic                  w_fill_empty;
    logic [P_CHNL_NUM-1:0] w_mask_eff;
    logic                  w_write;
    logic                  w_ovf;
    logic                  w_pick;
    logic [P_CHNL_NUM-1:0] w_em_mask;
    logic [LP_CW-1:0]      w_first_ch;
    logic [LP_CW-1:0]      w_next_ch;
    logic                  w_has_next;
    logic [P_DATA_WIDTH-1:0] w_sample;
    logic [1:0]            w_bsel;

    function automatic logic [7:0] f_len(input logic [P_CHNL_NUM-1:0] m);
        int n;
        n = 0;
        for (int k = 0; k < P_CHNL_NUM; k++) n += int'(m[k]);
        return 8'(3 + P_SETS_PER_PKT * n * LP_BYTES);
    endfunction

    assign w_hs   = o_adc_valid & i_adc_ready;
    assign w_free = w_hs & o_adc_last;

    // A bank freed this cycle is immediately available to an arriving set.
    always_comb begin
        w_full_eff[0] = r_full[0] & ~(w_free & ~r_emit);
        w_full_eff[1] = r_full[1] & ~(w_free & r_emit);
        w_fill        = w_full_eff[r_fill] ? ~r_fill : r_fill;
        w_room        = ~w_full_eff[w_fill];
        w_fill_empty  = (r_cnt[w_fill] == '0);
        w_mask_eff    = w_fill_empty ? i_chnl_mask : r_mask[w_fill];
        w_write       = i_sample_valid & i_enable & w_room & (|w_mask_eff);
        w_ovf         = i_sample_valid & i_enable & ~w_room;
        w_pick        = (&r_full) ? r_old : r_full[1];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_full    <= 2'b00;
            r_cnt[0]  <= '0;
            r_cnt[1]  <= '0;
            r_mask[0] <= '0;
            r_mask[1] <= '0;
            r_len[0]  <= 8'd0;
            r_len[1]  <= 8'd0;
            r_fill    <= 1'b0;
            r_old     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_fill <= w_fill;
            if (w_ovf) r_ovf <= 1'b1;
            if (w_free) r_full[r_emit] <= 1'b0;
            if (!i_enable) begin
                r_cnt[0] <= '0;
                r_cnt[1] <= '0;
            end else if (w_write) begin
                if (w_fill_empty) begin
                    r_mask[w_fill] <= i_chnl_mask;
                    r_len[w_fill]  <= f_len(i_chnl_mask);
                end
                if (r_cnt[w_fill] == LP_SET_LAST) begin
                    r_full[w_fill] <= 1'b1;
                    r_cnt[w_fill]  <= '0;
                    if (!w_full_eff[~w_fill]) r_old <= w_fill;
                end else begin
                    r_cnt[w_fill] <= r_cnt[w_fill] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write) r_mem[w_fill][r_cnt[w_fill]] <= i_sample_data;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|r_full) w_state_nxt = ST_HEAD;
            ST_HEAD: if (w_hs)    w_state_nxt = ST_MASK;
            ST_MASK: if (w_hs)    w_state_nxt = ST_SEQ;
            ST_SEQ:  if (w_hs)    w_state_nxt = ST_DATA;
            ST_DATA: if (w_free)  w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    // Payload walk: set-major, then enabled channels low to high, MSB byte first.
    always_comb begin
        w_em_mask  = r_mask[r_emit];
        w_first_ch = '0;
        w_next_ch  = '0;
        w_has_next = 1'b0;
        for (int k = P_CHNL_NUM - 1; k >= 0; k--) begin
            if (w_em_mask[k]) w_first_ch = LP_CW'(k);
            if (w_em_mask[k] && (k > int'(r_ch))) begin
                w_next_ch  = LP_CW'(k);
                w_has_next = 1'b1;
            end
        end
        w_sample = r_mem[r_emit][r_set][r_ch*P_DATA_WIDTH +: P_DATA_WIDTH];
        w_bsel   = LP_BYTE_LAST - r_byte;
    end

    always_comb begin
        o_adc_valid = 1'b0;
        o_adc_data  = 8'd0;
        o_adc_len   = 8'd0;
        o_adc_last  = 1'b0;
        if (r_state != ST_IDLE) begin
            o_adc_valid = 1'b1;
            o_adc_len   = r_len[r_emit];
        end
        case (r_state)
            ST_HEAD: o_adc_data = P_HEADER;
            ST_MASK: o_adc_data = 8'(w_em_mask);
            ST_SEQ:  o_adc_data = r_seq;
            ST_DATA: begin
                o_adc_data = w_sample[w_bsel*8 +: 8];
                o_adc_last = (r_bcnt == r_len[r_emit] - 8'd1);
            end
            default: o_adc_data = 8'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_emit    <= 1'b0;
            r_set     <= '0;
            r_ch      <= '0;
            r_byte    <= 2'd0;
            r_bcnt    <= 8'd0;
            r_seq     <= 8'd0;
            r_pkt_cnt <= 16'd0;
        end else if (r_state == ST_IDLE) begin
            if (|r_full) begin
                r_emit <= w_pick;
                r_bcnt <= 8'd0;
            end
        end else if (w_hs) begin
            r_bcnt <= r_bcnt + 8'd1;
            if (r_state == ST_SEQ) begin
                r_set  <= '0;
                r_ch   <= w_first_ch;
                r_byte <= 2'd0;
            end else if (r_state == ST_DATA) begin
                if (w_free) begin
                    r_seq     <= r_seq + 8'd1;
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                end else if (r_byte == LP_BYTE_LAST) begin
                    r_byte <= 2'd0;
                    if (w_has_next) begin
                        r_ch <= w_next_ch;
                    end else begin
                        r_ch  <= w_first_ch;
                        r_set <= r_set + 1'b1;
                    end
                end else begin
                    r_byte <= r_byte + 2'd1;
                end
            end
        end
    end

    assign o_overflow = r_ovf;
    assign o_pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_adc_multi_chnl_pkt.sv
// tb/tb_adc_multi_chnl_pkt.sv - directed self-checking bench for adc_multi_chnl_pkt
module tb_adc_multi_chnl_pkt;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [7:0]   mask;
    logic [127:0] sdata;
    logic         svalid;
    logic         rdy;
    logic [7:0]   o_adc_data;
    logic [7:0]   o_adc_len;
    logic         o_adc_last;
    logic         o_adc_valid;
    logic         o_overflow;
    logic [15:0]  o_pkt_cnt;

    int           total = 0;
    int           bad   = 0;
    logic [7:0]   rx_q[$];
    logic [7:0]   exp_q[$];
    logic [7:0]   rx_len;

    adc_multi_chnl_pkt dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_enable       (en),
        .i_chnl_mask    (mask),
        .i_sample_data  (sdata),
        .i_sample_valid (svalid),
        .i_adc_ready    (rdy),
        .o_adc_data     (o_adc_data),
        .o_adc_len      (o_adc_len),
        .o_adc_last     (o_adc_last),
        .o_adc_valid    (o_adc_valid),
        .o_overflow     (o_overflow),
        .o_pkt_cnt      (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_set(input logic [15:0] c0, input logic [15:0] c7);
        sdata  = {c7, 96'h0, c0};
        svalid = 1'b1;
        @(negedge clk);
        svalid = 1'b0;
    endtask

    task automatic exp_head(input logic [7:0] m, input logic [7:0] seq);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(m);
        exp_q.push_back(seq);
    endtask

    task automatic exp_word(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Collects one packet; optional ready toggling checks hold-stability and constant len.
    task automatic rx_pkt(input bit tog);
        int         guard;
        int         err;
        bit         done;
        bit         ph;
        bit         stall;
        logic [7:0] hold;
        rx_q.delete();
        guard = 0; err = 0; done = 1'b0; ph = 1'b0;
        while (!o_adc_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("rx_start", 32'(o_adc_valid), 32'd1);
        rx_len = o_adc_len;
        while (o_adc_valid && !done && guard < 400) begin
            rdy = tog ? ph : 1'b1;
            ph  = ~ph;
            if (o_adc_len !== rx_len) err++;
            if (rdy) begin
                rx_q.push_back(o_adc_data);
                done = o_adc_last;
            end
            stall = !rdy;
            hold  = o_adc_data;
            @(negedge clk);
            guard++;
            if (stall && o_adc_valid && o_adc_data !== hold) err++;
        end
        rdy = 1'b1;
        chk("rx_done", 32'(done), 32'd1);
        chk("rx_hold_len", 32'(err), 32'd0);
        chk("rx_idle_gap", 32'(o_adc_valid), 32'd0);
    endtask

    task automatic chk_pkt(input string tag);
        int n;
        chk({tag, "_size"}, 32'(rx_q.size()), 32'(exp_q.size()));
        chk({tag, "_len"}, 32'(rx_len), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int vcnt;
        int guard;
        rst_n = 1'b0; en = 1'b0; mask = 8'h00; sdata = '0; svalid = 1'b0; rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(o_adc_valid), 32'd0);
        chk("rst_data", 32'(o_adc_data), 32'd0);
        chk("rst_len", 32'(o_adc_len), 32'd0);
        chk("rst_last", 32'(o_adc_last), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_pktcnt", 32'(o_pkt_cnt), 32'd0);
        rst_n = 1'b1; en = 1'b1; mask = 8'h01;
        @(negedge clk);

        send_set(16'h1234, 16'h0); send_set(16'h5678, 16'h0);
        send_set(16'h9ABC, 16'h0); send_set(16'hDEF0, 16'h0);
        chk("swap_lat0", 32'(o_adc_valid), 32'd0);
        @(negedge clk);
        chk("swap_lat1", 32'(o_adc_valid), 32'd1);
        rx_pkt(1'b0);
        exp_head(8'h01, 8'h00);
        exp_word(16'h1234); exp_word(16'h5678); exp_word(16'h9ABC); exp_word(16'hDEF0);
        chk_pkt("p1");
        chk("p1_pktcnt", 32'(o_pkt_cnt), 32'd1);

        mask = 8'h81;
        repeat (4) send_set(16'h0102, 16'h0304);
        rx_pkt(1'b0);
        exp_head(8'h81, 8'h01);
        repeat (4) begin exp_word(16'h0102); exp_word(16'h0304); end
        chk_pkt("p2");

        repeat (4) send_set(16'h0102, 16'h0304);
        rx_pkt(1'b1);
        exp_head(8'h81, 8'h02);
        repeat (4) begin exp_word(16'h0102); exp_word(16'h0304); end
        chk_pkt("p3_bp");
        chk("p3_pktcnt", 32'(o_pkt_cnt), 32'd3);

        rdy = 1'b0; mask = 8'h01;
        for (int i = 0; i < 8; i++) send_set(16'h1000 + 16'(i), 16'h0);
        chk("ovf_before", 32'(o_overflow), 32'd0);
        send_set(16'h1008, 16'h0);
        chk("ovf_after", 32'(o_overflow), 32'd1);
        rx_pkt(1'b0);
        exp_head(8'h01, 8'h03);
        for (int i = 0; i < 4; i++) exp_word(16'h1000 + 16'(i));
        chk_pkt("p4a");
        rx_pkt(1'b0);
        exp_head(8'h01, 8'h04);
        for (int i = 4; i < 8; i++) exp_word(16'h1000 + 16'(i));
        chk_pkt("p4b");
        chk("p4_pktcnt", 32'(o_pkt_cnt), 32'd5);

        send_set(16'hAAAA, 16'h0); send_set(16'hBBBB, 16'h0);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        send_set(16'h1111, 16'h0); send_set(16'h2222, 16'h0);
        send_set(16'h3333, 16'h0); send_set(16'h4444, 16'h0);
        rx_pkt(1'b0);
        exp_head(8'h01, 8'h05);
        exp_word(16'h1111); exp_word(16'h2222); exp_word(16'h3333); exp_word(16'h4444);
        chk_pkt("p5_en");
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_adc_valid) vcnt++;
        end
        chk("p5_no_extra", 32'(vcnt), 32'd0);
        chk("p5_pktcnt", 32'(o_pkt_cnt), 32'd6);

        send_set(16'h0A0B, 16'h0); send_set(16'h0C0D, 16'h0);
        send_set(16'h0E0F, 16'h0); send_set(16'h1011, 16'h0);
        guard = 0;
        while (!o_adc_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("p6_start", 32'(o_adc_valid), 32'd1);
        repeat (4) @(negedge clk);
        chk("p6_mid_data", 32'(o_adc_data), 32'h0B);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_adc_valid), 32'd0);
        chk("arst_len", 32'(o_adc_len), 32'd0);
        chk("arst_pktcnt", 32'(o_pkt_cnt), 32'd0);
        chk("arst_ovf", 32'(o_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(o_adc_valid), 32'd0);
        send_set(16'h1234, 16'h0); send_set(16'h5678, 16'h0);
        send_set(16'h9ABC, 16'h0); send_set(16'hDEF0, 16'h0);
        rx_pkt(1'b0);
        exp_head(8'h01, 8'h00);
        exp_word(16'h1234); exp_word(16'h5678); exp_word(16'h9ABC); exp_word(16'hDEF0);
        chk_pkt("p7_rst");
        chk("p7_pktcnt", 32'(o_pkt_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
